instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Upstream fetch stage for the single-cycle MIPS core. Owns the PC, requests words from
//  instruction memory over a req/ack handshake, and holds the fetched word stable for the
//  control decoder and datapath (Inst[31:26] feeds CONTROL). Computes next-PC from the
//  decoded Branch/Branch_Not_Equal/Jump flags and ALU Zero. Exports PC+4 as the jal link value.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  CNT_W      32             width of Retired_Count
// PORTS
//  Clk              in   1      clock, rising edge
//  Rst              in   1      asynchronous, active-high reset
//  Imem_Req         out  1      fetch request to instruction memory
//  Imem_Addr        out  32     fetch address (= PC)
//  Imem_Ack         in   1      memory has valid data on Imem_Data this cycle
//  Imem_Data        in   32     instruction word
//  Stall            in   1      downstream hold; freezes the current instruction
//  Branch           in   1      from CONTROL (beq)
//  Branch_Not_Equal in   1      from CONTROL (bne)
//  Jump             in   1      from CONTROL (j/jal)
//  Zero             in   1      ALU zero flag for the current instruction
//  Inst             out  32     held instruction word
//  Inst_Valid       out  1      Inst is executing this cycle; gates all state writes downstream
//  PC               out  32     address of Inst
//  PC_Plus4         out  32     PC + 4 (jal link, Mem_to_Reg=2'b10)
//  Retired_Count    out  CNT_W  number of instructions retired
// BEHAVIOUR
//  Reset values: PC=RESET_PC, Inst=0, Inst_Valid=0, Imem_Req=0, Retired_Count=0, state=IDLE.
//  Imem_Addr is driven from PC at all times.
//  States:
//   - IDLE:  lasts 1 cycle after reset release, then goes to FETCH.
//   - FETCH: Imem_Req=1.
//       - On a rising edge with Imem_Ack=1: Inst<=Imem_Data, go to EXEC.
//       - Otherwise stay in FETCH; Req and Addr stay stable until Ack.
//       - Ack may arrive in the same cycle Req first rises (zero-wait memory).
//   - EXEC:  Imem_Req=0, Inst_Valid=1. Control and ALU outputs settle combinationally.
//       - Stall=1: stay in EXEC; PC, Inst and Retired_Count are held.
//       - Stall=0: PC<=Next_PC, Retired_Count+=1, go to FETCH.
//  Imem_Ack outside FETCH is ignored.
//  Next_PC, evaluated in EXEC; Imm = sign-extended Inst[15:0]. Priority high to low:
//   - Jump=1: {PC_Plus4[31:28], Inst[25:0], 2'b00}.
//   - (Branch & Zero) | (Branch_Not_Equal & ~Zero): PC_Plus4 + (Imm<<2), mod 2^32.
//   - Otherwise: PC_Plus4.
//  Jump wins over the branch flags when both are set. Branch and Branch_Not_Equal both set:
//   - Either true condition causes the branch to be taken.
//  Arithmetic: PC_Plus4 = PC + 4, mod 2^32; PC 32'hFFFF_FFFC wraps to 0.
//   - Backward branch offsets wrap the same way.
//   - PC[1:0] is always 0; no misalignment is possible.
//  Throughput: 2 cycles per instruction minimum (FETCH with immediate Ack, then EXEC).
//  Retired_Count wraps to 0 at 2^CNT_W-1 + 1.
//  Rst asserted mid-FETCH: Imem_Req drops asynchronously and any in-flight Ack is discarded.
//   - After release the fetch restarts at RESET_PC via IDLE.
//  Rst asserted mid-EXEC: the instruction is not retired and Inst_Valid drops immediately.
//  Stall during FETCH has no effect; it is only sampled in EXEC.
// TESTING
//  1. Reset release, Ack tied 1, sequential non-branch words:
//     -> Imem_Addr 0,4,8,...; Inst_Valid every 2nd cycle; Retired_Count 1,2,3.
//  2. beq at PC=0x10, Imm=16'hFFFC, Zero=1 -> next Imem_Addr=0x04.
//     Same with Zero=0 -> 0x14. bne with Zero=0 -> 0x04.
//  3. jal at PC=0x4000_0000, Inst[25:0]=26'h000_0040, Jump=1
//     -> PC_Plus4=0x4000_0004 during EXEC; next Imem_Addr=0x4000_0100.
//  4. Memory holds Ack low 3 cycles -> Req stays 1 and Addr stable for 4 cycles.
//     Stall=1 for 2 cycles in EXEC -> Inst, PC and Retired_Count are frozen.
//  5. Rst pulse mid-FETCH at PC=0x20 -> Req=0 and Inst_Valid=0 immediately.
//     After release, the first request is at RESET_PC and the late Ack is ignored.
//  6. PC=0xFFFF_FFFC with a non-branch instruction -> next Imem_Addr=0x0000_0000.
//     Jump with Branch=1 also set -> the jump target is taken.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Instruction-memory fetch bus: the fetch stage issues Imem_Req/Imem_Addr and
// the memory answers with Imem_Ack/Imem_Data in the cycle the word is valid.
interface instruction_fetch_if;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;

    modport master (output Imem_Req, output Imem_Addr, input Imem_Ack, input Imem_Data);
    modport slave  (input Imem_Req, input Imem_Addr, output Imem_Ack, output Imem_Data);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage for the single-cycle MIPS core: owns the PC, fetches over req/ack, holds Inst for decode.
// At least 2 cycles per instruction (FETCH then EXEC); waits in FETCH for Ack and holds in EXEC while Stall.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    instruction_fetch_if.master  imem,
    input  logic                 Stall_i,
    input  logic                 Branch_i,
    input  logic                 Branch_Not_Equal_i,
    input  logic                 Jump_i,
    input  logic                 Zero_i,
    output logic [31:0]          Inst_o,
    output logic                 Inst_Valid_o,
    output logic [31:0]          PC_o,
    output logic [31:0]          PC_Plus4_o,
    output logic [CNT_W-1:0]     Retired_Count_o
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pc_plus4;
    logic [31:0]        branch_off;
    logic [31:0]        next_pc;
    logic               take_branch;
    logic               req;
    logic               valid;

    assign pc_plus4    = pc_q + 32'd4;
    assign branch_off  = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    assign take_branch = (Branch_i & Zero_i) | (Branch_Not_Equal_i & ~Zero_i);

    // Jump outranks any branch flag that CONTROL may also raise.
    always_comb begin
        next_pc = pc_plus4;
        if (Jump_i) begin
            next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        valid   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                req = 1'b1;
                if (imem.Imem_Ack) begin
                    inst_d  = imem.Imem_Data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                valid = 1'b1;
                if (!Stall_i) begin
                    pc_d    = next_pc;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    // Req and Valid decode straight from the state register so reset removes them at once.
    assign imem.Imem_Req  = req;
    assign imem.Imem_Addr = pc_q;
    assign Inst_o          = inst_q;
    assign Inst_Valid_o    = valid;
    assign PC_o            = pc_q;
    assign PC_Plus4_o      = pc_plus4;
    assign Retired_Count_o = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table of chained instructions plus hand-written corner sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_hi = 1'b1;
    logic        stall = 1'b0, branch = 1'b0, bne = 1'b0, jump = 1'b0, zero = 1'b0;
    logic [31:0] inst, pc, plus4, inst_hi, pc_hi, plus4_hi;
    logic        valid, valid_hi;
    logic [31:0] cnt, cnt_hi;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instruction_fetch_if imem ();
    instruction_fetch_if imem_hi ();

    instruction_fetch dut (
        .Clk(clk), .Rst(rst), .imem(imem),
        .Stall_i(stall), .Branch_i(branch), .Branch_Not_Equal_i(bne), .Jump_i(jump), .Zero_i(zero),
        .Inst_o(inst), .Inst_Valid_o(valid), .PC_o(pc), .PC_Plus4_o(plus4), .Retired_Count_o(cnt)
    );

    instruction_fetch #(.RESET_PC(32'h4000_0000), .CNT_W(32)) dut_hi (
        .Clk(clk), .Rst(rst_hi), .imem(imem_hi),
        .Stall_i(stall), .Branch_i(branch), .Branch_Not_Equal_i(bne), .Jump_i(jump), .Zero_i(zero),
        .Inst_o(inst_hi), .Inst_Valid_o(valid_hi), .PC_o(pc_hi), .PC_Plus4_o(plus4_hi), .Retired_Count_o(cnt_hi)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br, bne, jmp, zero;
        logic [31:0] plus4;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [31:0] p, input logic [31:0] i, input logic b, input logic n,
                                input logic j, input logic z, input logic [31:0] p4, input logic [31:0] nx);
        vec_t v;
        v.pc = p; v.inst = i; v.br = b; v.bne = n; v.jmp = j; v.zero = z; v.plus4 = p4; v.next = nx;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_req();
        bit seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (imem.Imem_Req === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_req: got no Imem_Req, expected Imem_Req within 20 cycles");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = mk(32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0004, 32'h0000_0004);
        vecs[1]  = mk(32'h0000_0004, 32'h0042_0820, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_0008);
        vecs[2]  = mk(32'h0000_0008, 32'h0000_0001, 0, 0, 0, 1, 32'h0000_000C, 32'h0000_000C);
        vecs[3]  = mk(32'h0000_000C, 32'h0800_0004, 0, 0, 1, 0, 32'h0000_0010, 32'h0000_0010);
        vecs[4]  = mk(32'h0000_0010, 32'h1000_FFFC, 1, 0, 0, 1, 32'h0000_0014, 32'h0000_0004);
        vecs[5]  = mk(32'h0000_0004, 32'h0800_0004, 0, 0, 1, 0, 32'h0000_0008, 32'h0000_0010);
        vecs[6]  = mk(32'h0000_0010, 32'h1000_FFFC, 1, 0, 0, 0, 32'h0000_0014, 32'h0000_0014);
        vecs[7]  = mk(32'h0000_0014, 32'h0800_0004, 0, 0, 1, 0, 32'h0000_0018, 32'h0000_0010);
        vecs[8]  = mk(32'h0000_0010, 32'h1400_FFFC, 0, 1, 0, 0, 32'h0000_0014, 32'h0000_0004);
        vecs[9]  = mk(32'h0000_0004, 32'h1400_0010, 0, 1, 0, 1, 32'h0000_0008, 32'h0000_0008);
        vecs[10] = mk(32'h0000_0008, 32'h1000_0004, 1, 1, 0, 0, 32'h0000_000C, 32'h0000_001C);
        vecs[11] = mk(32'h0000_001C, 32'h0800_0008, 1, 0, 1, 1, 32'h0000_0020, 32'h0000_0020);
        vecs[12] = mk(32'h0000_0020, 32'h1000_FFF6, 1, 0, 0, 1, 32'h0000_0024, 32'hFFFF_FFFC);
        vecs[13] = mk(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000);
        vecs[14] = mk(32'h0000_0000, 32'h1000_7FFF, 1, 0, 0, 1, 32'h0000_0004, 32'h0002_0000);
        vecs[15] = mk(32'h0002_0000, 32'h1400_8000, 0, 1, 0, 0, 32'h0002_0004, 32'h0000_0004);
        vecs[16] = mk(32'h0000_0004, 32'h0000_0000, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_0008);

        imem.Imem_Ack = 1'b1;
        imem.Imem_Data = 32'h0;
        imem_hi.Imem_Ack = 1'b0;
        imem_hi.Imem_Data = 32'h0;

        #2;
        chk("rst_req", {31'h0, imem.Imem_Req}, 32'h0);
        chk("rst_addr", imem.Imem_Addr, 32'h0);
        chk("rst_valid", {31'h0, valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_cnt", cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            wait_req();
            chk($sformatf("v%0d_fetch_addr", i), imem.Imem_Addr, vecs[i].pc);
            imem.Imem_Data = vecs[i].inst;
            branch = vecs[i].br; bne = vecs[i].bne; jump = vecs[i].jmp; zero = vecs[i].zero;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), {31'h0, valid}, 32'h1);
            chk($sformatf("v%0d_inst", i), inst, vecs[i].inst);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].pc);
            chk($sformatf("v%0d_plus4", i), plus4, vecs[i].plus4);
            chk($sformatf("v%0d_cnt_exec", i), cnt, i);
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'h0, imem.Imem_Req}, 32'h1);
            chk($sformatf("v%0d_next_addr", i), imem.Imem_Addr, vecs[i].next);
            chk($sformatf("v%0d_valid_low", i), {31'h0, valid}, 32'h0);
            chk($sformatf("v%0d_cnt_ret", i), cnt, i + 1);
            branch = 0; bne = 0; jump = 0; zero = 0;
        end

        // Memory wait states: Ack low for 3 edges, Req/Addr must hold.
        imem.Imem_Ack = 1'b0;
        imem.Imem_Data = 32'h0000_0002;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("wait%0d_req", k), {31'h0, imem.Imem_Req}, 32'h1);
            chk($sformatf("wait%0d_addr", k), imem.Imem_Addr, 32'h0000_0008);
        end
        imem.Imem_Ack = 1'b1;
        @(negedge clk);
        stall = 1'b1;
        imem.Imem_Data = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("stall%0d_valid", k), {31'h0, valid}, 32'h1);
            chk($sformatf("stall%0d_inst", k), inst, 32'h0000_0002);
            chk($sformatf("stall%0d_pc", k), pc, 32'h0000_0008);
            chk($sformatf("stall%0d_cnt", k), cnt, 32'd17);
            chk($sformatf("stall%0d_req", k), {31'h0, imem.Imem_Req}, 32'h0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("unstall_addr", imem.Imem_Addr, 32'h0000_000C);
        chk("unstall_cnt", cnt, 32'd18);

        // Stall while fetching must not delay the fetch.
        stall = 1'b1;
        imem.Imem_Data = 32'h0800_0008;
        jump = 1'b1;
        @(negedge clk);
        chk("fstall_valid", {31'h0, valid}, 32'h1);
        chk("fstall_inst", inst, 32'h0800_0008);
        stall = 1'b0;
        imem.Imem_Ack = 1'b0;
        @(negedge clk);
        jump = 1'b0;
        chk("fstall_addr", imem.Imem_Addr, 32'h0000_0020);
        chk("fstall_cnt", cnt, 32'd19);

        // Reset in the middle of a pending fetch at 0x20.
        #2;
        rst = 1'b1;
        imem.Imem_Ack = 1'b1;
        imem.Imem_Data = 32'hDEAD_BEEF;
        #1;
        chk("mrst_req", {31'h0, imem.Imem_Req}, 32'h0);
        chk("mrst_valid", {31'h0, valid}, 32'h0);
        chk("mrst_addr", imem.Imem_Addr, 32'h0);
        chk("mrst_cnt", cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_req", {31'h0, imem.Imem_Req}, 32'h0);
        @(negedge clk);
        chk("refetch_req", {31'h0, imem.Imem_Req}, 32'h1);
        chk("refetch_addr", imem.Imem_Addr, 32'h0);
        chk("refetch_inst", inst, 32'h0);
        chk("refetch_valid", {31'h0, valid}, 32'h0);
        imem.Imem_Ack = 1'b0;
        @(negedge clk);
        chk("refetch_hold", {31'h0, imem.Imem_Req}, 32'h1);
        imem.Imem_Ack = 1'b1;
        imem.Imem_Data = 32'h0000_0003;
        @(negedge clk);
        chk("refetch_exec_inst", inst, 32'h0000_0003);
        chk("refetch_exec_pc", pc, 32'h0);
        chk("refetch_exec_valid", {31'h0, valid}, 32'h1);

        // jal from the 0x4000_0000 region on the second instance.
        rst = 1'b1;
        jump = 1'b1;
        imem_hi.Imem_Ack = 1'b1;
        imem_hi.Imem_Data = 32'h0C00_0040;
        @(negedge clk);
        rst_hi = 1'b0;
        begin
            bit seen = 0;
            for (int k = 0; k < 20; k++) begin
                if (imem_hi.Imem_Req === 1'b1) begin
                    seen = 1;
                    break;
                end
                @(negedge clk);
            end
            n_tests++;
            if (!seen) begin
                n_fail++;
                $display("FAIL hi_wait_req: got no Imem_Req, expected Imem_Req within 20 cycles");
            end
        end
        chk("jal_fetch_addr", imem_hi.Imem_Addr, 32'h4000_0000);
        @(negedge clk);
        chk("jal_valid", {31'h0, valid_hi}, 32'h1);
        chk("jal_plus4", plus4_hi, 32'h4000_0004);
        @(negedge clk);
        chk("jal_next_addr", imem_hi.Imem_Addr, 32'h4000_0100);
        jump = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
